cdb_arbiter: RTL and testbench

- Arbitrates the three execution units (ALU, MEM, branch) onto one common data bus (CDB).
- The CDB broadcasts each result to the physical register file, the reservation-station wakeup logic and the ROB completion logic.
- Each FU gets a 1-entry holding buffer. A round-robin grant drains one buffer per cycle into a registered CDB output.
- Sits between the FU outputs and the writeback/wakeup consumers.

---
 rtl/cdb_arbiter.sv | 175 +++++++++++++++++
 tb/tb_cdb_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Purpose: round-robin arbiter that moves ALU/MEM/branch results onto one registered common data bus.
// Latency: a result accepted at edge E is broadcast after edge E+1, so it is visible one cycle later.
// Backpressure: each FU has a 1-entry buffer; *_ready drops while that buffer waits for a grant or during flush.
//
// Ports:
//   clk, reset (sync, active-high), flush (drops buffered and incoming results)
//   {alu,mem,br}_valid/_pd/_rob/_result in, {alu,mem,br}_ready out, br_mispredict in
//   cdb_valid/_pd/_rob/_data/_rf_we/_src/_mispredict out (registered)
//   Build option CDB_STATS_EN adds stall_alu/stall_mem/stall_br/grant_total saturating counters.
module cdb_arbiter #(
  parameter int PREG_W = 7,
  parameter int ROB_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              alu_valid,
  input  logic [PREG_W-1:0] alu_pd,
  input  logic [ROB_W-1:0]  alu_rob,
  input  logic [DATA_W-1:0] alu_result,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [PREG_W-1:0] mem_pd,
  input  logic [ROB_W-1:0]  mem_rob,
  input  logic [DATA_W-1:0] mem_result,
  output logic              mem_ready,
  input  logic              br_valid,
  input  logic [PREG_W-1:0] br_pd,
  input  logic [ROB_W-1:0]  br_rob,
  input  logic [DATA_W-1:0] br_result,
  output logic              br_ready,
  input  logic              br_mispredict,
  output logic              cdb_valid,
  output logic [PREG_W-1:0] cdb_pd,
  output logic [ROB_W-1:0]  cdb_rob,
  output logic [DATA_W-1:0] cdb_data,
  output logic              cdb_rf_we,
  output logic [1:0]        cdb_src,
  output logic              cdb_mispredict
`ifdef CDB_STATS_EN
  ,
  output logic [31:0]       stall_alu,
  output logic [31:0]       stall_mem,
  output logic [31:0]       stall_br,
  output logic [31:0]       grant_total
`endif
);

  localparam logic [1:0] SRC_BR = 2'd2;

  typedef struct packed {
    logic [PREG_W-1:0] pd;
    logic [ROB_W-1:0]  rob;
    logic [DATA_W-1:0] data;
    logic              mispredict;
  } entry_t;

  function automatic logic [1:0] wrap_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  entry_t     in_ent [3];
  logic [2:0] in_vld;
  entry_t     buf_q  [3];
  logic [2:0] buf_v;
  logic [1:0] rr_ptr;
  logic [2:0] grant;
  logic [2:0] ready;
  logic [2:0] accept;
  logic [1:0] win;
  logic [1:0] idx;
  logic       any_grant;

  // Only the branch unit carries a mispredict flag; the other slots store 0.
  always_comb begin
    in_ent[0] = '{pd: alu_pd, rob: alu_rob, data: alu_result, mispredict: 1'b0};
    in_ent[1] = '{pd: mem_pd, rob: mem_rob, data: mem_result, mispredict: 1'b0};
    in_ent[2] = '{pd: br_pd,  rob: br_rob,  data: br_result,  mispredict: br_mispredict};
    in_vld    = {br_valid, mem_valid, alu_valid};
  end

  // Search rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3); first occupied buffer wins.
  always_comb begin
    grant     = '0;
    win       = '0;
    any_grant = 1'b0;
    idx       = rr_ptr;
    for (int k = 0; k < 3; k++) begin
      if (!any_grant && buf_v[idx]) begin
        any_grant = 1'b1;
        win       = idx;
      end
      idx = wrap_inc(idx);
    end
    if (any_grant) grant[win] = 1'b1;
  end

  // A buffer being drained this cycle may be refilled at the same edge.
  assign ready     = {3{~flush}} & (~buf_v | grant);
  assign accept    = in_vld & ready;
  assign alu_ready = ready[0];
  assign mem_ready = ready[1];
  assign br_ready  = ready[2];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < 3; s++) buf_q[s] <= '0;
      buf_v          <= '0;
      rr_ptr         <= 2'd0;
      cdb_valid      <= 1'b0;
      cdb_pd         <= '0;
      cdb_rob        <= '0;
      cdb_data       <= '0;
      cdb_rf_we      <= 1'b0;
      cdb_src        <= 2'd0;
      cdb_mispredict <= 1'b0;
    end else if (flush) begin
      buf_v          <= '0;
      cdb_valid      <= 1'b0;
      cdb_rf_we      <= 1'b0;
      cdb_mispredict <= 1'b0;
    end else begin
      for (int s = 0; s < 3; s++) begin
        if (accept[s]) begin
          buf_q[s] <= in_ent[s];
          buf_v[s] <= 1'b1;
        end else if (grant[s]) begin
          buf_v[s] <= 1'b0;
        end
      end
      if (any_grant) begin
        cdb_valid      <= 1'b1;
        cdb_pd         <= buf_q[win].pd;
        cdb_rob        <= buf_q[win].rob;
        cdb_data       <= buf_q[win].data;
        cdb_src        <= win;
        // pd 0 is the hardwired zero register: broadcast for ROB completion only.
        cdb_rf_we      <= |buf_q[win].pd;
        cdb_mispredict <= (win == SRC_BR) && buf_q[win].mispredict;
        rr_ptr         <= wrap_inc(win);
      end else begin
        // Payload holds; the strobes that qualify it drop with cdb_valid.
        cdb_valid      <= 1'b0;
        cdb_rf_we      <= 1'b0;
        cdb_mispredict <= 1'b0;
      end
    end
  end

`ifdef CDB_STATS_EN
  logic [2:0] stall;
  assign stall = buf_v & ~grant;

  function automatic logic [31:0] sat_inc(input logic [31:0] c, input logic en);
    return (en && (c != '1)) ? c + 32'd1 : c;
  endfunction

  // Statistics survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_alu   <= '0;
      stall_mem   <= '0;
      stall_br    <= '0;
      grant_total <= '0;
    end else begin
      stall_alu   <= sat_inc(stall_alu, stall[0]);
      stall_mem   <= sat_inc(stall_mem, stall[1]);
      stall_br    <= sat_inc(stall_br,  stall[2]);
      grant_total <= sat_inc(grant_total, cdb_valid);
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Purpose: self-checking bench for cdb_arbiter (vector table plus hand sequences, scoreboarded).
// Latency: expects each accepted result on the CDB one cycle after the edge following acceptance.
// Backpressure: the bench holds a source's valid and payload until that source's ready is seen.
module tb_cdb_arbiter;

  typedef struct packed {
    logic [6:0]  pd;
    logic [4:0]  rob;
    logic [31:0] data;
    logic        misp;
  } ent_t;

  typedef struct {
    logic [2:0] mask;
    int         n;
    logic [5:0] ord;   // broadcast order, src k at ord[2k+:2]
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        alu_valid, mem_valid, br_valid, br_mispredict;
  logic [6:0]  alu_pd, mem_pd, br_pd;
  logic [4:0]  alu_rob, mem_rob, br_rob;
  logic [31:0] alu_result, mem_result, br_result;
  logic        alu_ready, mem_ready, br_ready;
  logic        cdb_valid, cdb_rf_we, cdb_mispredict;
  logic [6:0]  cdb_pd;
  logic [4:0]  cdb_rob;
  logic [31:0] cdb_data;
  logic [1:0]  cdb_src;
`ifdef CDB_STATS_EN
  logic [31:0] stall_alu, stall_mem, stall_br, grant_total;
`endif

  int tests = 0;
  int fails = 0;
  ent_t q_alu[$], q_mem[$], q_br[$];
  logic [1:0] src_q[$];
  int max_wait [3];
  vec_t vecs [10];

  always #5 clk = ~clk;

  cdb_arbiter dut (
    .clk(clk), .reset(reset), .flush(flush),
    .alu_valid(alu_valid), .alu_pd(alu_pd), .alu_rob(alu_rob), .alu_result(alu_result), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_pd(mem_pd), .mem_rob(mem_rob), .mem_result(mem_result), .mem_ready(mem_ready),
    .br_valid(br_valid), .br_pd(br_pd), .br_rob(br_rob), .br_result(br_result), .br_ready(br_ready),
    .br_mispredict(br_mispredict),
    .cdb_valid(cdb_valid), .cdb_pd(cdb_pd), .cdb_rob(cdb_rob), .cdb_data(cdb_data),
    .cdb_rf_we(cdb_rf_we), .cdb_src(cdb_src), .cdb_mispredict(cdb_mispredict)
`ifdef CDB_STATS_EN
    , .stall_alu(stall_alu), .stall_mem(stall_mem), .stall_br(stall_br), .grant_total(grant_total)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic ent_t rand_ent(input int s);
    ent_t e;
    e.pd   = 7'($urandom_range(0, 127));
    e.rob  = 5'($urandom_range(0, 31));
    e.data = $urandom;
    e.misp = (s == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    return e;
  endfunction

  task automatic drive_src(input int s, input logic v, input ent_t e);
    case (s)
      0: begin alu_valid = v; alu_pd = e.pd; alu_rob = e.rob; alu_result = e.data; end
      1: begin mem_valid = v; mem_pd = e.pd; mem_rob = e.rob; mem_result = e.data; end
      default: begin br_valid = v; br_pd = e.pd; br_rob = e.rob; br_result = e.data; br_mispredict = e.misp; end
    endcase
  endtask

  task automatic push_exp(input int s, input ent_t e);
    case (s)
      0: q_alu.push_back(e);
      1: q_mem.push_back(e);
      default: q_br.push_back(e);
    endcase
  endtask

  task automatic clear_inputs();
    for (int s = 0; s < 3; s++) drive_src(s, 1'b0, '0);
  endtask

  // Scoreboard: every broadcast is matched against the expected source order and that source's queue.
  always @(negedge clk) begin
    if (!reset && cdb_valid === 1'b1) begin
      ent_t e;
      logic got;
      got = 1'b1;
      if (src_q.size() == 0) begin
        chk("unexpected_bcast", {62'd0, cdb_src}, 64'hFF);
      end else begin
        chk("cdb_src_order", {62'd0, cdb_src}, {62'd0, src_q.pop_front()});
      end
      case (cdb_src)
        2'd0: if (q_alu.size() > 0) e = q_alu.pop_front(); else got = 1'b0;
        2'd1: if (q_mem.size() > 0) e = q_mem.pop_front(); else got = 1'b0;
        2'd2: if (q_br.size()  > 0) e = q_br.pop_front();  else got = 1'b0;
        default: got = 1'b0;
      endcase
      if (!got) begin
        chk("bcast_no_expected_entry", {62'd0, cdb_src}, 64'hFF);
      end else begin
        chk("cdb_pd",   {57'd0, cdb_pd},   {57'd0, e.pd});
        chk("cdb_rob",  {59'd0, cdb_rob},  {59'd0, e.rob});
        chk("cdb_data", {32'd0, cdb_data}, {32'd0, e.data});
        chk("cdb_rf_we", {63'd0, cdb_rf_we}, {63'd0, (e.pd != 7'd0)});
        chk("cdb_mispredict", {63'd0, cdb_mispredict}, {63'd0, e.misp});
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; flush = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_cdb_valid"}, {63'd0, cdb_valid}, 64'd0);
    chk({tag, "_cdb_pd"},    {57'd0, cdb_pd},    64'd0);
    chk({tag, "_cdb_rob"},   {59'd0, cdb_rob},   64'd0);
    chk({tag, "_cdb_data"},  {32'd0, cdb_data},  64'd0);
    chk({tag, "_cdb_src"},   {62'd0, cdb_src},   64'd0);
    chk({tag, "_cdb_rf_we"}, {63'd0, cdb_rf_we}, 64'd0);
    chk({tag, "_cdb_misp"},  {63'd0, cdb_mispredict}, 64'd0);
    chk({tag, "_readies"},   {61'd0, br_ready, mem_ready, alu_ready}, 64'd7);
  endtask

  // One-cycle injection into empty buffers; returns at the negedge after the accepting edge.
  task automatic inject(input logic [2:0] mask, input ent_t ea, input ent_t em, input ent_t eb, input bit push);
    ent_t ev [3];
    ev[0] = ea; ev[1] = em; ev[2] = eb;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      if (mask[s]) begin
        drive_src(s, 1'b1, ev[s]);
        chk("inject_ready", {63'd0, (s == 0) ? alu_ready : (s == 1) ? mem_ready : br_ready}, 64'd1);
        if (push) push_exp(s, ev[s]);
      end
    end
    @(posedge clk);
    @(negedge clk);
    clear_inputs();
  endtask

  // Streams cnt results per masked source with valid/ready handshake; tracks longest wait per source.
  task automatic stream(input logic [2:0] mask, input int cnt);
    int   rem [3];
    int   wt  [3];
    ent_t cur [3];
    logic [2:0] rdy;
    int   guard;
    for (int s = 0; s < 3; s++) begin
      rem[s] = mask[s] ? cnt : 0;
      wt[s] = 0;
      max_wait[s] = 0;
      cur[s] = rand_ent(s);
    end
    guard = 0;
    while ((rem[0] + rem[1] + rem[2]) > 0 && guard < 200) begin
      @(negedge clk);
      for (int s = 0; s < 3; s++) drive_src(s, rem[s] > 0, cur[s]);
      rdy = {br_ready, mem_ready, alu_ready};
      @(posedge clk);
      #1;
      for (int s = 0; s < 3; s++) begin
        if (rem[s] > 0) begin
          if (rdy[s]) begin
            push_exp(s, cur[s]);
            rem[s]--;
            wt[s] = 0;
            cur[s] = rand_ent(s);
          end else begin
            wt[s]++;
            if (wt[s] > max_wait[s]) max_wait[s] = wt[s];
          end
        end
      end
      guard++;
    end
    if (guard >= 200) chk("stream_timeout", 64'(guard), 64'd0);
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic drain_check(input string name);
    repeat (4) @(negedge clk);
    chk(name, 64'(src_q.size() + q_alu.size() + q_mem.size() + q_br.size()), 64'd0);
  endtask

  initial begin
    ent_t e;
    reset = 1'b1; flush = 1'b0;
    clear_inputs();

    // Round-robin order table; each vector starts from the pointer the previous one left.
    vecs[0] = '{mask: 3'b111, n: 3, ord: {2'd2, 2'd1, 2'd0}};
    vecs[1] = '{mask: 3'b110, n: 2, ord: {2'd0, 2'd2, 2'd1}};
    vecs[2] = '{mask: 3'b101, n: 2, ord: {2'd0, 2'd2, 2'd0}};
    vecs[3] = '{mask: 3'b010, n: 1, ord: {2'd0, 2'd0, 2'd1}};
    vecs[4] = '{mask: 3'b111, n: 3, ord: {2'd1, 2'd0, 2'd2}};
    vecs[5] = '{mask: 3'b011, n: 2, ord: {2'd0, 2'd1, 2'd0}};
    vecs[6] = '{mask: 3'b100, n: 1, ord: {2'd0, 2'd0, 2'd2}};
    vecs[7] = '{mask: 3'b110, n: 2, ord: {2'd0, 2'd2, 2'd1}};
    vecs[8] = '{mask: 3'b001, n: 1, ord: {2'd0, 2'd0, 2'd0}};
    vecs[9] = '{mask: 3'b111, n: 3, ord: {2'd0, 2'd2, 2'd1}};

    do_reset();
    chk_reset_state("rst");

    // Single ALU result, then ALU+MEM together to show the pointer moved to MEM.
    e = '{pd: 7'd5, rob: 5'd3, data: 32'hDEADBEEF, misp: 1'b0};
    src_q.push_back(2'd0);
    inject(3'b001, e, '0, '0, 1'b1);
    chk("t1_not_yet_valid", {63'd0, cdb_valid}, 64'd0);
    @(negedge clk);
    chk("t1_cdb_valid", {63'd0, cdb_valid}, 64'd1);
    chk("t1_rf_we", {63'd0, cdb_rf_we}, 64'd1);
    src_q.push_back(2'd1); src_q.push_back(2'd0);
    inject(3'b011, rand_ent(0), rand_ent(1), '0, 1'b1);
    drain_check("t1_drain");

    // All three at once from pointer 0: unserved sources are held off.
    do_reset();
    src_q.push_back(2'd0); src_q.push_back(2'd1); src_q.push_back(2'd2);
    inject(3'b111, rand_ent(0), rand_ent(1), rand_ent(2), 1'b1);
    chk("t2_ready_e0", {61'd0, br_ready, mem_ready, alu_ready}, 64'b001);
    @(negedge clk);
    chk("t2_ready_e1", {61'd0, br_ready, mem_ready, alu_ready}, 64'b011);
    @(negedge clk);
    chk("t2_ready_e2", {61'd0, br_ready, mem_ready, alu_ready}, 64'b111);
    drain_check("t2_drain");

    do_reset();
    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].n; k++) src_q.push_back(vecs[i].ord[2*k +: 2]);
      inject(vecs[i].mask, rand_ent(0), rand_ent(1), rand_ent(2), 1'b1);
      drain_check("vec_drain");
    end

    // ALU alone, 8 back-to-back: never stalled.
    do_reset();
    for (int k = 0; k < 8; k++) src_q.push_back(2'd0);
    stream(3'b001, 8);
    chk("t3_alu_max_wait", 64'(max_wait[0]), 64'd0);
    drain_check("t3_drain");

    // ALU and MEM continuous: grants alternate, each waits exactly one cycle.
    do_reset();
    for (int k = 0; k < 4; k++) begin src_q.push_back(2'd0); src_q.push_back(2'd1); end
    stream(3'b011, 4);
    chk("t4_alu_max_wait", 64'(max_wait[0]), 64'd1);
    chk("t4_mem_max_wait", 64'(max_wait[1]), 64'd1);
    drain_check("t4_drain");

    // Flush with MEM/BR buffered; pointer (1) must survive the flush.
    do_reset();
    src_q.push_back(2'd0);
    inject(3'b001, rand_ent(0), '0, '0, 1'b1);
    repeat (2) @(negedge clk);
    inject(3'b110, '0, rand_ent(1), rand_ent(2), 1'b0);
    flush = 1'b1;
    drive_src(0, 1'b1, rand_ent(0));
    #1;
    chk("t5_ready_in_flush", {61'd0, br_ready, mem_ready, alu_ready}, 64'b000);
    @(negedge clk);
    flush = 1'b0;
    clear_inputs();
    #1;
    chk("t5_valid_after_flush", {63'd0, cdb_valid}, 64'd0);
    chk("t5_ready_after_flush", {61'd0, br_ready, mem_ready, alu_ready}, 64'b111);
    drain_check("t5_no_leak");
    src_q.push_back(2'd1); src_q.push_back(2'd2); src_q.push_back(2'd0);
    inject(3'b111, rand_ent(0), rand_ent(1), rand_ent(2), 1'b1);
    drain_check("t5_drain");

    // Branch with pd 0 and mispredict, waiting behind ALU and MEM.
    do_reset();
    e = '{pd: 7'd0, rob: 5'd9, data: 32'h0BAD_F00D, misp: 1'b1};
    src_q.push_back(2'd0); src_q.push_back(2'd1); src_q.push_back(2'd2);
    inject(3'b111, rand_ent(0), rand_ent(1), e, 1'b1);
    repeat (3) @(negedge clk);
    chk("t6_src", {62'd0, cdb_src}, 64'd2);
    chk("t6_rf_we", {63'd0, cdb_rf_we}, 64'd0);
    chk("t6_misp", {63'd0, cdb_mispredict}, 64'd1);
    drain_check("t6_drain");
`ifdef CDB_STATS_EN
    chk("t6_stall_alu", {32'd0, stall_alu}, 64'd0);
    chk("t6_stall_mem", {32'd0, stall_mem}, 64'd1);
    chk("t6_stall_br",  {32'd0, stall_br},  64'd2);
    chk("t6_grant_total", {32'd0, grant_total}, 64'd3);
`endif

    // Reset right after acceptance: nothing may reach the bus.
    inject(3'b111, rand_ent(0), rand_ent(1), rand_ent(2), 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk_reset_state("t7");
    drain_check("t7_no_leak");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
